jtframe_frac_cen_multi: RTL and testbench
=========================================

# jtframe_frac_cen_multi

Multi-channel fractional clock-enable generator for cores that need several unrelated CPU, sound and video enables derived from one system clock. Each channel produces a W-bit set of clock enables at rate n/m of `clk`, with each higher bit at half the previous rate, plus a half-period-shifted set. It adds three things the single-channel generator lacks:

- glitch-free runtime ratio reload;
- a global run/pause and phase-sync control;
- per-channel sticky error reporting.

## Interface
Parameters:
- NCH, 2, number of independent channels
- W, 2, enables per channel (bit k toggles at rate/2^k); W>=2
- WC, 10, numerator/denominator width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- n  in  NCH*WC  numerators, channel c at [c*WC+:WC]
- m  in  NCH*WC  denominators, same packing
- ld  in  NCH  per-channel load strobe; captures n/m of that channel into pending
- run  in  1  1 = count, 0 = freeze all channels
- sync  in  1  synchronous phase restart of all channels
- cen  out  NCH*W  clock enables, channel c at [c*W+:W]
- cenb  out  NCH*W  180-degree shifted enables, same packing
- err  out  NCH  sticky accumulator-overflow flag per channel
- pend  out  NCH  1 while a loaded ratio awaits application

## Operation
Per-channel state:
- acc (WC+1 bits)
- n_act, m_act (active ratio)
- n_pnd, m_pnd (pending ratio)
- half flag
- edgecnt, edgecnt_b (W bits each)

Reset (rst_n low, asynchronous):
- every register above is 0; cen = cenb = err = pend = 0.
- m_act = 0 means the channel is disabled.

Ratio loading:
- ld[c]=1 loads n_pnd = min(n,m) (clamping prevents n>m) and m_pnd = m, and sets pend[c].
- A second ld before application overwrites the pending ratio.
- Pending ratio is applied (n_act/m_act updated, pend cleared) in the first cycle where any of these holds:
  - the channel is disabled (m_act==0);
  - sync=1;
  - an "over" event occurs on that channel.
- On an over event, next-acc is computed with the old ratio; the new ratio takes effect from the following cycle.
- ld and application in the same cycle: the new ld value wins and pend stays 1.

Per cycle, with run=1, sync=0 and m_act!=0:
- next = acc + n_act
- over = next >= m_act
- halfway = next >= (m_act>>1) and !half
- If acc >= m_act + n_act: acc<=0, err[c]<=1, no pulses this cycle.
- Otherwise:
  - halfway: half<=1, edgecnt_b++, cenb <= {toggle_b[W-2:0],1}, where toggle_b = (edgecnt_b+1) & ~edgecnt_b.
  - over: acc<=next-m_act, half<=0, edgecnt++, cen <= {toggle[W-2:0],1}.
  - not over: acc<=next.
  - over and halfway in the same cycle: both pulse.

Control inputs:
- run=0: all state held, cen=cenb=0. ld and ratio application while disabled still work.
- sync=1 (priority over run): acc, half, edgecnt, edgecnt_b <= 0 on all channels; cen=cenb=0 that cycle; pending ratios applied.
- Disabled channel (m_act==0): acc held 0, no pulses.
- err clears only by reset.

## Timing
- cen/cenb are registered, single-cycle pulses, asserted the cycle after the evaluating cycle.
- From ld on a disabled channel at edge t:
  - n_act valid after edge t+1;
  - first accumulation at t+1.
- With n==m, cen[0] is high every cycle from t+2.
- Long-run average of cen[0]: exactly n_act/m_act pulses per clk.
- cen[k] (k>=1) pulses on every 2^k-th cen[0] pulse; cenb likewise relative to cenb[0].
- run deassert: pulses stop the next cycle. run reassert resumes the sequence exactly where frozen.
- Mid-operation reset: outputs drop to 0 asynchronously. Counting resumes only after a new ld.

## Test plan
- Reset, ld ch0 with n=1, m=4 -> cen[0] every 4th cycle, cen[1] every 8th, cenb[0] 2 cycles after each cen[0], pend low after 1 cycle.
- ch1 n=3, m=8 over 800 cycles -> exactly 300 cen[0] pulses, 150 cen[1]; ch0 unaffected.
- Running n=1, m=4, ld with n=1, m=2 mid-period -> pend high until next cen[0]; thereafter cen[0] every 2 cycles; no short or extra pulse.
- sync asserted mid-period, then run low for 10 cycles -> counters zero; identical pulse train restarts; no pulses while run=0.
- Force acc to 0x3FF -> err[c]=1 sticky, acc=0 next cycle, normal pulses resume.
- rst_n low mid-run for 1 cycle -> all outputs 0 immediately, no pulses until new ld; ld n=5, m=3 -> clamped, cen[0] every cycle.

Source files
------------

// File: rtl/jtframe_frac_cen_multi.sv
// jtframe_frac_cen_multi: multi-channel fractional n/m clock-enable generator
// with glitch-free ratio reload, run/sync control and sticky overflow flags
module jtframe_frac_cen_multi #(
   parameter int NCH = 2,
   parameter int W   = 2,
   parameter int WC  = 10
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH*WC-1:0] n,
   input  logic [NCH*WC-1:0] m,
   input  logic [NCH-1:0]    ld,
   input  logic              run,
   input  logic              sync,
   output logic [NCH*W-1:0]  cen,
   output logic [NCH*W-1:0]  cenb,
   output logic [NCH-1:0]    err,
   output logic [NCH-1:0]    pend
);
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [WC-1:0] n_act, m_act, n_pnd, m_pnd, n_in, m_in, n_clamp;
      logic [WC:0]   acc, rem;
      logic [WC+1:0] nxt, lim;
      logic [W-1:0]  edgecnt, edgecnt_b, cen_r, cenb_r;
      logic [W-2:0]  tgl, tgl_b;
      logic          half, act, bad, over, halfway, apply, err_r, pend_r;
      always_comb begin
         n_in    = n[c*WC+:WC];
         m_in    = m[c*WC+:WC];
         n_clamp = n_in > m_in ? m_in : n_in;
         nxt     = {1'b0, acc} + {2'b0, n_act};
         lim     = {2'b0, m_act} + {2'b0, n_act};
         rem     = nxt[WC:0] - {1'b0, m_act};
         act     = run && !sync && m_act != '0;
         bad     = {1'b0, acc} >= lim;
         over    = act && !bad && nxt >= {2'b0, m_act};
         halfway = act && !bad && !half && nxt >= {3'b0, m_act[WC-1:1]};
         apply   = pend_r && (m_act == '0 || sync || over);
         tgl     = (edgecnt[W-2:0] + 1'b1) & ~edgecnt[W-2:0];
         tgl_b   = (edgecnt_b[W-2:0] + 1'b1) & ~edgecnt_b[W-2:0];
      end
      // a fresh ld in the same cycle as an application stays pending
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            n_act     <= '0;
            m_act     <= '0;
            n_pnd     <= '0;
            m_pnd     <= '0;
            acc       <= '0;
            half      <= 1'b0;
            edgecnt   <= '0;
            edgecnt_b <= '0;
            cen_r     <= '0;
            cenb_r    <= '0;
            err_r     <= 1'b0;
            pend_r    <= 1'b0;
         end else begin
            n_pnd     <= ld[c] ? n_clamp : n_pnd;
            m_pnd     <= ld[c] ? m_in : m_pnd;
            pend_r    <= ld[c] || (pend_r && !apply);
            n_act     <= apply ? n_pnd : n_act;
            m_act     <= apply ? m_pnd : m_act;
            acc       <= (sync || m_act == '0) ? '0 : !act ? acc : bad ? '0 : over ? rem : nxt[WC:0];
            half      <= (sync || over) ? 1'b0 : halfway ? 1'b1 : half;
            edgecnt   <= sync ? '0 : edgecnt + W'(over);
            edgecnt_b <= sync ? '0 : edgecnt_b + W'(halfway);
            cen_r     <= over ? {tgl, 1'b1} : '0;
            cenb_r    <= halfway ? {tgl_b, 1'b1} : '0;
            err_r     <= err_r || (act && bad);
         end
      assign cen[c*W+:W]  = cen_r;
      assign cenb[c*W+:W] = cenb_r;
      assign err[c]       = err_r;
      assign pend[c]      = pend_r;
   end
endmodule

// File: tb/tb_jtframe_frac_cen_multi.sv
// tb_jtframe_frac_cen_multi: directed vector table, corner sequences and a
// randomized run checked against a closed-form floor(s*n/m) reference
module tb_jtframe_frac_cen_multi;
   localparam int NCH = 2, W = 2, WC = 10, NV = 40;
   logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, sync = 1'b0;
   logic [NCH*WC-1:0] n = '0, m = '0;
   logic [NCH-1:0]    ld = '0, err, pend, ep;
   logic [NCH*W-1:0]  cen, cenb, ec, ecb;
   int checks = 0, errors = 0;
   int an[NCH], am[NCH], pn[NCH], pm[NCH], s[NCH], kb[NCH];
   bit pp[NCH];
   int cnt, c0, c10, c11, t, tp, p, kk, nv, mv;
   bit ov, st, hw;

   typedef struct {
      logic ld; int nv; int mv; logic run; logic sync;
      logic [W-1:0] cen; logic [W-1:0] cenb; logic pend;
   } vec_t;
   vec_t tbl[NV];

   jtframe_frac_cen_multi #(.NCH(NCH), .W(W), .WC(WC)) dut (
      .clk(clk), .rst_n(rst_n), .n(n), .m(m), .ld(ld), .run(run), .sync(sync),
      .cen(cen), .cenb(cenb), .err(err), .pend(pend)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int c, input int nvv, input int mvv);
      n[c*WC+:WC] = WC'(nvv);
      m[c*WC+:WC] = WC'(mvv);
   endtask

   task automatic row(input int i, input logic [W-1:0] c, input logic [W-1:0] cb, input logic pd);
      tbl[i].cen  = c;
      tbl[i].cenb = cb;
      tbl[i].pend = pd;
   endtask

   initial begin
      for (int i = 0; i < NV; i++) begin
         tbl[i].ld = 0; tbl[i].nv = 0; tbl[i].mv = 0; tbl[i].run = 1; tbl[i].sync = 0;
         tbl[i].cen = '0; tbl[i].cenb = '0; tbl[i].pend = 0;
      end
      tbl[0].ld = 1; tbl[0].nv = 1; tbl[0].mv = 4; row(0, 2'b00, 2'b00, 1);
      row(3, 2'b00, 2'b11, 0); row(5, 2'b11, 2'b00, 0); row(7, 2'b00, 2'b01, 0);
      row(9, 2'b01, 2'b00, 0); row(11, 2'b00, 2'b11, 0); row(13, 2'b11, 2'b00, 0);
      // reload to 1/2 mid-period: waits for the next cen[0]
      tbl[14].ld = 1; tbl[14].nv = 1; tbl[14].mv = 2; row(14, 2'b00, 2'b00, 1);
      row(15, 2'b00, 2'b01, 1); row(16, 2'b00, 2'b00, 1); row(17, 2'b01, 2'b00, 0);
      row(18, 2'b00, 2'b11, 0); row(19, 2'b11, 2'b00, 0); row(20, 2'b00, 2'b01, 0);
      row(21, 2'b01, 2'b00, 0); row(22, 2'b00, 2'b11, 0); row(23, 2'b11, 2'b00, 0);
      row(24, 2'b00, 2'b01, 0);
      tbl[25].sync = 1;
      for (int i = 26; i < 36; i++) tbl[i].run = 0;
      row(36, 2'b00, 2'b11, 0); row(37, 2'b11, 2'b00, 0); row(38, 2'b00, 2'b01, 0);
      row(39, 2'b01, 2'b00, 0);

      #12;
      chk("reset_outputs", {cen, cenb, pend, err}, 0);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < NV; i++) begin
         ld[0] = tbl[i].ld;
         if (tbl[i].ld) set_ch(0, tbl[i].nv, tbl[i].mv);
         run  = tbl[i].run;
         sync = tbl[i].sync;
         tick;
         chk($sformatf("vec%0d", i), {cen, cenb, pend, err},
             {2'b00, tbl[i].cen, 2'b00, tbl[i].cenb, 1'b0, tbl[i].pend, 2'b00});
      end
      ld = '0; run = 1; sync = 0;
      tick;
      chk("pre_rst_cenb", cenb, 4'b0011);
      #2 rst_n = 1'b0;
      #1 chk("async_rst", {cen, cenb, pend, err}, 0);
      @(negedge clk) rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick;
         cnt += int'(cen != 0) + int'(cenb != 0) + int'(pend != 0);
      end
      chk("no_pulse_after_rst", cnt, 0);

      // n>m is clamped, giving n==m: cen[0] every cycle
      set_ch(0, 5, 3); ld = 2'b01;
      tick;
      chk("clamp_pend", pend, 2'b01);
      ld = '0;
      tick;
      chk("clamp_first", {cen, pend}, 0);
      for (int i = 0; i < 8; i++) begin
         tick;
         chk("clamp_cen0", cen[0], 1'b1);
      end

      // leftover acc from 7/8 exceeds the new 1/2 ratio: overflow path
      set_ch(1, 7, 8); ld = 2'b10;
      tick;
      ld = '0;
      tick;
      chk("err_apply", pend[1], 1'b0);
      set_ch(1, 1, 2); ld = 2'b10;
      tick;
      chk("err_s1", {cenb[3:2], pend[1]}, 3'b111);
      ld = '0;
      tick;
      chk("err_over", {cen[3:2], pend[1], err}, 5'b11000);
      tick;
      chk("err_set", {cen[3:2], cenb[3:2], err}, 6'b000010);
      tick;
      chk("err_resume_b", {cenb[3:2], err}, 4'b0110);
      tick;
      chk("err_resume", {cen[3:2], err}, 4'b0110);

      set_ch(1, 3, 8); ld = 2'b10;
      tick;
      ld = '0; sync = 1;
      tick;
      sync = 0;
      chk("cnt_applied", pend[1], 1'b0);
      c0 = 0; c10 = 0; c11 = 0;
      for (int i = 0; i < 800; i++) begin
         tick;
         c0  += int'(cen[0]);
         c10 += int'(cen[2]);
         c11 += int'(cen[3]);
      end
      chk("cnt_ch1_cen0", c10, 300);
      chk("cnt_ch1_cen1", c11, 150);
      chk("cnt_ch0_cen0", c0, 800);
      chk("err_sticky", err, 2'b10);

      for (int r = 0; r < 3; r++) begin
         ld = '0; run = 0; sync = 0; rst_n = 1'b0;
         #3 rst_n = 1'b1;
         for (int c = 0; c < NCH; c++) begin
            an[c] = 0; am[c] = 0; pp[c] = 0; s[c] = 0; kb[c] = 0;
            mv = $urandom_range(1, 64);
            nv = $urandom_range(1, 70);
            set_ch(c, nv, mv);
         end
         for (int cyc = 0; cyc < 600; cyc++) begin
            ld   = cyc == 0 ? '1 : '0;
            run  = ($urandom % 8) != 0;
            sync = cyc > 2 && ($urandom % 50) == 0;
            ec = '0; ecb = '0;
            for (int c = 0; c < NCH; c++) begin
               if (sync) begin
                  s[c] = 0; kb[c] = 0;
               end else if (run && am[c] != 0) begin
                  s[c]++;
                  t  = s[c] * an[c];
                  tp = (s[c] - 1) * an[c];
                  p  = tp / am[c];
                  ov = t / am[c] > p;
                  st = s[c] == 1 ? 1'b1 : (p > ((s[c] - 2) * an[c]) / am[c]);
                  hw = (t - p * am[c] >= am[c] / 2) && (st || (tp - p * am[c] < am[c] / 2));
                  if (ov) begin
                     kk = t / am[c];
                     ec[c*W] = 1'b1;
                     for (int k = 1; k < W; k++) ec[c*W+k] = (kk % (1 << k)) == (1 << (k - 1));
                  end
                  if (hw) begin
                     kb[c]++;
                     ecb[c*W] = 1'b1;
                     for (int k = 1; k < W; k++) ecb[c*W+k] = (kb[c] % (1 << k)) == (1 << (k - 1));
                  end
               end
               if (pp[c] && (am[c] == 0 || sync)) begin
                  an[c] = pn[c]; am[c] = pm[c]; pp[c] = 0; s[c] = 0; kb[c] = 0;
               end
               if (ld[c]) begin
                  nv = int'(n[c*WC+:WC]);
                  mv = int'(m[c*WC+:WC]);
                  pn[c] = nv > mv ? mv : nv;
                  pm[c] = mv;
                  pp[c] = 1;
               end
               ep[c] = pp[c];
            end
            tick;
            chk($sformatf("rand r%0d c%0d", r, cyc), {cen, cenb, pend, err}, {ec, ecb, ep, 2'b00});
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
